fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding unit of the pipelined ARMv8 core.
- Resolves RAW hazards for NUM_SRC source operands.
- Uses strict EX/MEM-over-MEM/WB forwarding priority, with a configurable zero register.
- Adds a load-use stall state machine supporting multi-cycle load latency, a memory-busy freeze, and a saturating stall-cycle counter.
- Sits between the ID/EX pipeline register and the EX operand muxes; drives PC, IF/ID write enables and the ID/EX bubble.

Parameters:
- NUM_SRC, 2, number of source operands checked per instruction (1..4).
- ADDR_W, 5, register address width.
- ZERO_REG, 31, register index that never forwards and never causes a stall (XZR).
- LOAD_LAT, 1, bubbles inserted on a load-use hazard (1..15).
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- IF_ID_Src  in  NUM_SRC*ADDR_W  source register addresses of the instruction in ID; operand i at bits [i*ADDR_W +: ADDR_W]
- IF_ID_SrcValid  in  NUM_SRC  per-operand "operand is actually read" flag
- ID_EX_Src  in  NUM_SRC*ADDR_W  source register addresses of the instruction in EX
- ID_EX_RegisterRd  in  ADDR_W  destination register in EX
- ID_EX_MemRead  in  1  instruction in EX is a load
- EX_MEM_RegWrite  in  1
- EX_MEM_RegisterRd  in  ADDR_W
- MEM_WB_RegWrite  in  1
- MEM_WB_RegisterRd  in  ADDR_W
- MEM_Busy  in  1  data memory not ready; freezes the whole pipeline
- Forward  out  NUM_SRC*2  per-operand select: 00 register file, 10 EX/MEM, 01 MEM/WB
- PC_Write  out  1  PC may update
- IF_ID_Write  out  1  IF/ID may update
- ID_EX_Flush  out  1  load a bubble (all control bits zero) into ID/EX
- Stall  out  1  OR of all stall causes
- StallCount  out  CNT_W  total cycles with Stall=1

Behaviour:
- Forwarding (combinational; every output fully assigned in every evaluation, no latches), for each operand i:
  - If EX_MEM_RegWrite && EX_MEM_RegisterRd != ZERO_REG && EX_MEM_RegisterRd == ID_EX_Src[i] -> 10.
  - Else if MEM_WB_RegWrite && MEM_WB_RegisterRd != ZERO_REG && MEM_WB_RegisterRd == ID_EX_Src[i] -> 01.
  - Else -> 00.
  - Forwarding is independent of stall state.
- Hazard detect (combinational): hz = ID_EX_MemRead && ID_EX_RegisterRd != ZERO_REG && some i with IF_ID_SrcValid[i] && IF_ID_Src[i] == ID_EX_RegisterRd.
- FSM states: RUN, LSTALL. Down-counter cnt is 4 bits.
  - RUN, hz=1, MEM_Busy=0:
    - Stall this cycle: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
    - If LOAD_LAT>1: cnt<=LOAD_LAT-1, go to LSTALL. Otherwise stay in RUN.
  - LSTALL: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. cnt decrements each cycle; when cnt==1, go to RUN on the next edge.
  - Exactly LOAD_LAT bubbles are inserted per load-use hazard.
  - hz is ignored while in LSTALL, because ID/EX already holds a bubble.
- MEM_Busy=1 has the highest priority:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=0 (ID/EX is held, not bubbled).
  - FSM state and cnt are frozen.
  - A hazard arriving during busy is evaluated once busy drops.
- Stall = ~PC_Write.
- StallCount increments on each clk edge where Stall=1 and saturates at all-ones (no wrap).
- No stall, no busy: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0.
- Reset (async, any time including mid-stall):
  - State RUN, cnt=0, StallCount=0.
  - Outputs settle to PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, Stall=0.
  - Forward follows its inputs.
- Latency: Forward and stall controls have zero-cycle (combinational) latency; state and counters update on the rising clk edge.

Test Plan:
- EX_MEM_RegWrite=1, EX_MEM_RegisterRd=3, MEM_WB_RegWrite=1, MEM_WB_RegisterRd=3, ID_EX_Src={3,3} -> Forward=1010 (EX/MEM wins); set EX_MEM_RegWrite=0 -> 0101.
- EX_MEM_RegisterRd=31 and MEM_WB_RegisterRd=31, RegWrites=1, ID_EX_Src={31,31} -> Forward=0000.
- LOAD_LAT=1: ID_EX_MemRead=1, ID_EX_RegisterRd=5, IF_ID_Src[0]=5, valid=01 -> one cycle with PC_Write=0 and ID_EX_Flush=1, StallCount 0->1. Repeat with valid=00 -> no stall.
- LOAD_LAT=3: same hazard -> exactly 3 consecutive stall cycles, then PC_Write=1, StallCount=3.
- LOAD_LAT=3: MEM_Busy=1 for 2 cycles during LSTALL -> ID_EX_Flush=0 while busy, cnt frozen; total stall cycles = 5, StallCount=5.
- Assert reset in the second cycle of LSTALL -> PC_Write=1 immediately, StallCount=0, state RUN after release. Separately, preload StallCount near all-ones and stall -> saturates at all-ones.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding and load-use hazard unit.
// Forwarding is purely combinational. The load-use stall is a two-state FSM
// with a 4-bit down-counter that inserts LOAD_LAT bubbles. MEM_Busy freezes
// the whole pipeline and holds ID/EX instead of bubbling it.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*ADDR_W-1:0]   IF_ID_Src,
  input  logic [NUM_SRC-1:0]          IF_ID_SrcValid,
  input  logic [NUM_SRC*ADDR_W-1:0]   ID_EX_Src,
  input  logic [ADDR_W-1:0]           ID_EX_RegisterRd,
  input  logic                        ID_EX_MemRead,
  input  logic                        EX_MEM_RegWrite,
  input  logic [ADDR_W-1:0]           EX_MEM_RegisterRd,
  input  logic                        MEM_WB_RegWrite,
  input  logic [ADDR_W-1:0]           MEM_WB_RegisterRd,
  input  logic                        MEM_Busy,
  output logic [NUM_SRC*2-1:0]        Forward,
  output logic                        PC_Write,
  output logic                        IF_ID_Write,
  output logic                        ID_EX_Flush,
  output logic                        Stall,
  output logic [CNT_W-1:0]            StallCount
);

  localparam logic [ADDR_W-1:0] ZeroReg    = ADDR_W'(ZERO_REG);
  localparam logic [3:0]        LatMinus1  = 4'(LOAD_LAT - 1);
  localparam bit                MultiCycle = (LOAD_LAT > 1);

  typedef enum logic [0:0] {StRun, StLStall} stateT;

  stateT            stateQ, stateD;
  logic [3:0]       cntQ, cntD;
  logic [CNT_W-1:0] stallCntQ;
  logic             hz;

  // Per-operand forwarding select; EX/MEM has priority over MEM/WB
  always_comb begin
    Forward = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (EX_MEM_RegWrite && (EX_MEM_RegisterRd != ZeroReg) &&
          (EX_MEM_RegisterRd == ID_EX_Src[i*ADDR_W +: ADDR_W])) begin
        Forward[i*2 +: 2] = 2'b10;
      end else if (MEM_WB_RegWrite && (MEM_WB_RegisterRd != ZeroReg) &&
                   (MEM_WB_RegisterRd == ID_EX_Src[i*ADDR_W +: ADDR_W])) begin
        Forward[i*2 +: 2] = 2'b01;
      end else begin
        Forward[i*2 +: 2] = 2'b00;
      end
    end
  end

  // Load-use hazard: a load in EX writes a register that ID actually reads
  always_comb begin
    logic match;
    match = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (IF_ID_SrcValid[i] && (IF_ID_Src[i*ADDR_W +: ADDR_W] == ID_EX_RegisterRd)) begin
        match = 1'b1;
      end
    end
    hz = ID_EX_MemRead && (ID_EX_RegisterRd != ZeroReg) && match;
  end

  // State and bubble counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StRun;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Next-state logic; everything holds while memory is busy
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    if (!MEM_Busy) begin
      unique case (stateQ)
        StRun: begin
          // The first bubble is issued from RUN; LSTALL covers the rest
          if (hz && MultiCycle) begin
            cntD   = LatMinus1;
            stateD = StLStall;
          end
        end
        StLStall: begin
          cntD = cntQ - 4'd1;
          if (cntQ == 4'd1) begin
            stateD = StRun;
          end
        end
        default: begin
          stateD = StRun;
          cntD   = 4'd0;
        end
      endcase
    end
  end

  // Pipeline control outputs; busy holds ID/EX rather than bubbling it
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Flush = 1'b0;
    if (MEM_Busy) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end else if ((stateQ == StLStall) || hz) begin
      // hz is irrelevant in LSTALL since ID/EX already holds a bubble
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
    Stall = ~PC_Write;
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCntQ <= '0;
    end else if (Stall && (stallCntQ != {CNT_W{1'b1}})) begin
      stallCntQ <= stallCntQ + CNT_W'(1);
    end
  end

  assign StallCount = stallCntQ;

endmodule
